// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Oversampled UART receiver with configurable width, parity and
//            valid/ready output handshake with parity/framing/overrun flags.
// Revision : 1.0
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [c_TICK_W-1:0] c_HALF_LAST = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_FULL_LAST = c_TICK_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0]  c_BITS_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic                c_PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [c_TICK_W-1:0]    r_tick_cnt;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic [DATA_BITS-1:0]   r_data_out;
    logic                   r_data_valid;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_rx_s;
    logic w_half_tick;
    logic w_full_tick;
    logic w_count_en;
    logic w_shift_en;
    logic w_par_sample;
    logic w_stop_sample;
    logic w_accept;

    assign w_rx_s      = r_sync2;
    assign w_half_tick = baud_tick && (r_tick_cnt == c_HALF_LAST);
    assign w_full_tick = baud_tick && (r_tick_cnt == c_FULL_LAST);
    assign w_count_en  = r_state inside {S_START, S_DATA, S_PARITY, S_STOP};
    assign w_accept    = r_data_valid && data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_shift_en    = 1'b0;
        w_par_sample  = 1'b0;
        w_stop_sample = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (baud_tick && !w_rx_s) w_state_next = S_START;
            end
            S_START: begin
                // A start bit that is high again at its centre is a glitch.
                if (w_half_tick) w_state_next = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_full_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_BITS_LAST) begin
                        w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_full_tick) begin
                    w_par_sample = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_full_tick) begin
                    w_stop_sample = 1'b1;
                    w_state_next  = w_rx_s ? S_IDLE : S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until a break releases so it yields a single frame.
                if (w_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_tick_cnt <= '0;
        end else if (baud_tick && w_count_en) begin
            if (r_tick_cnt == c_FULL_LAST) r_tick_cnt <= '0;
            else                           r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_bit_cnt <= '0;
                r_par_err <= 1'b0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
            end
            if (w_shift_en) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (w_par_sample) r_par_err <= (((^r_shift) ^ w_rx_s) != c_PAR_ODD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_stop_sample && (!r_data_valid || data_ready)) begin
                r_data_out   <= r_shift;
                r_parity_err <= r_par_err;
                r_frame_err  <= ~w_rx_s;
                r_data_valid <= 1'b1;
            end else if (w_accept) begin
                r_data_valid <= 1'b0;
            end
            if (w_stop_sample && r_data_valid && !data_ready) r_overrun <= 1'b1;
            else if (w_accept)                                r_overrun <= 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Purpose  : Scoreboard bench for uart_rx_param (8N1 and 8E1 instances).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_param;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic baud_tick = 1'b0;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic ready0 = 1'b1;
    logic ready1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic valid0, valid1, pe0, pe1, fe0, fe1, ovr0, ovr1, busy0, busy1;
    logic m_s1 = 1'b1;
    logic m_s2 = 1'b1;

    int checks = 0;
    int errors = 0;
    int vcnt0 = 0;
    int vcnt1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx0),
        .data_out(dout0), .data_valid(valid0), .data_ready(ready0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx1),
        .data_out(dout1), .data_valid(valid1), .data_ready(ready1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ovr1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks.
    initial begin : g_tick
        int tc;
        tc = 0;
        forever begin
            @(posedge clk);
            #1 baud_tick = (tc == 3);
            tc = (tc + 1) % 4;
        end
    end

    // Model of the input synchronizer on rx0, used to time a coincident accept.
    always @(posedge clk) begin
        m_s1 <= rx0;
        m_s2 <= m_s1;
    end

    initial begin : g_watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
        exp_t r;
        r.d  = d;
        r.pe = pe;
        r.fe = fe;
        return r;
    endfunction

    task automatic monitor0();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid0) vcnt0++;
            if (valid0 && ready0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL mon0_unexpected got d=%h pe=%b fe=%b", dout0, pe0, fe0);
                end else begin
                    e = q0.pop_front();
                    if ({dout0, pe0, fe0} !== e) begin
                        errors++;
                        $display("FAIL mon0_word got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                                 dout0, pe0, fe0, e.d, e.pe, e.fe);
                    end
                end
            end
        end
    endtask

    task automatic monitor1();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid1) vcnt1++;
            if (valid1 && ready1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL mon1_unexpected got d=%h pe=%b fe=%b", dout1, pe1, fe1);
                end else begin
                    e = q1.pop_front();
                    if ({dout1, pe1, fe1} !== e) begin
                        errors++;
                        $display("FAIL mon1_word got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                                 dout1, pe1, fe1, e.d, e.pe, e.fe);
                    end
                end
            end
        end
    endtask

    // One bit period is 16 ticks = 64 clocks.
    task automatic hold_bit(input int sel, input logic b);
        @(posedge clk);
        #1;
        if (sel == 0) rx0 = b;
        else          rx1 = b;
        repeat (63) @(posedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic par_on,
                              input logic par_bit, input logic stop);
        hold_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
        if (par_on) hold_bit(sel, par_bit);
        hold_bit(sel, stop);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout0, valid0, pe0, fe0, ovr0, busy0} !== 13'd0) begin
            errors++;
            $display("FAIL reset_dut0 got %b want 0", {dout0, valid0, pe0, fe0, ovr0, busy0});
        end
        checks++;
        if ({dout1, valid1, pe1, fe1, ovr1, busy1} !== 13'd0) begin
            errors++;
            $display("FAIL reset_dut1 got %b want 0", {dout1, valid1, pe1, fe1, ovr1, busy1});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_8n1();
        int v;
        v = vcnt0;
        ready0 = 1'b1;
        q0.push_back(mk(8'hA5, 1'b0, 1'b0));
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vcnt0 - v !== 1) begin
            errors++;
            $display("FAIL 8n1_valid_cycles got %0d want 1", vcnt0 - v);
        end
        checks++;
        if ({busy0, valid0} !== 2'b00) begin
            errors++;
            $display("FAIL 8n1_idle got busy=%b valid=%b want 0 0", busy0, valid0);
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL 8n1_pending got %0d want 0", q0.size());
        end
    endtask

    task automatic test_back_to_back();
        int v;
        logic [7:0] pat [3];
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h96;
        v = vcnt0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(pat[i], 1'b0, 1'b0));
            send_frame(0, pat[i], 1'b0, 1'b0, 1'b1);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vcnt0 - v !== 3 || q0.size() != 0) begin
            errors++;
            $display("FAIL b2b_count got valid=%0d pending=%0d want 3 0", vcnt0 - v, q0.size());
        end
    endtask

    task automatic test_parity();
        ready1 = 1'b1;
        q1.push_back(mk(8'h07, 1'b0, 1'b0));
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        q1.push_back(mk(8'h07, 1'b1, 1'b0));
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout1, pe1, fe1} !== {8'h07, 1'b1, 1'b0} || q1.size() != 0) begin
            errors++;
            $display("FAIL parity_final got d=%h pe=%b fe=%b pending=%0d want 07 1 0 0",
                     dout1, pe1, fe1, q1.size());
        end
    endtask

    task automatic test_glitch();
        int v;
        v = vcnt0;
        @(posedge clk);
        #1 rx0 = 1'b0;
        repeat (12) @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high got %b want 1", busy0);
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || vcnt0 != v) begin
            errors++;
            $display("FAIL glitch_drop got busy=%b valid_cycles=%0d want 0 0", busy0, vcnt0 - v);
        end
    endtask

    // Raise ready0 only for the clock edge on which the stop bit is sampled.
    task automatic coincide_ready();
        int  n;
        bit  started;
        bit  hit;
        n = 0;
        started = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            @(posedge clk);
            if (baud_tick) begin
                if (!started) begin
                    if (!m_s2) started = 1'b1;
                end else begin
                    n++;
                    if (n == 151) hit = 1'b1;
                end
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL coincide_timeout got ticks=%0d want 151", n);
        end else begin
            repeat (3) @(posedge clk);
            #1 ready0 = 1'b1;
            @(posedge clk);
            #1 ready0 = 1'b0;
        end
    endtask

    task automatic test_overrun();
        ready0 = 1'b0;
        q0.push_back(mk(8'h11, 1'b0, 1'b0));
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({valid0, dout0, ovr0} !== {1'b1, 8'h11, 1'b1}) begin
            errors++;
            $display("FAIL overrun_hold got v=%b d=%h ovr=%b want 1 11 1", valid0, dout0, ovr0);
        end
        @(posedge clk);
        #1 ready0 = 1'b1;
        @(posedge clk);
        #1 ready0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid0, ovr0} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_clear got v=%b ovr=%b want 0 0", valid0, ovr0);
        end
        q0.push_back(mk(8'h33, 1'b0, 1'b0));
        send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
        q0.push_back(mk(8'h44, 1'b0, 1'b0));
        fork
            send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1);
            coincide_ready();
        join
        @(negedge clk);
        checks++;
        if ({valid0, dout0, ovr0} !== {1'b1, 8'h44, 1'b0} || q0.size() != 1) begin
            errors++;
            $display("FAIL coincide_load got v=%b d=%h ovr=%b pending=%0d want 1 44 0 1",
                     valid0, dout0, ovr0, q0.size());
        end
        @(posedge clk);
        #1 ready0 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b0 || q0.size() != 0) begin
            errors++;
            $display("FAIL coincide_drain got v=%b pending=%0d want 0 0", valid0, q0.size());
        end
    endtask

    task automatic test_break();
        int v;
        ready0 = 1'b1;
        v = vcnt0;
        q0.push_back(mk(8'hF0, 1'b0, 1'b1));
        send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b0);
        repeat (40 * 64) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vcnt0 - v !== 1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL break_single got valid_cycles=%0d busy=%b want 1 1", vcnt0 - v, busy0);
        end
        @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (20) @(posedge clk);
        q0.push_back(mk(8'h3C, 1'b0, 1'b0));
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vcnt0 - v !== 2 || q0.size() != 0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL break_recover got valid_cycles=%0d pending=%0d busy=%b want 2 0 0",
                     vcnt0 - v, q0.size(), busy0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h5A;
        hold_bit(1, 1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1, d[i]);
        @(posedge clk);
        #1 rx1 = d[4];
        repeat (32) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({dout1, valid1, pe1, fe1, ovr1, busy1} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_dut1 got %b want 0", {dout1, valid1, pe1, fe1, ovr1, busy1});
        end
        checks++;
        if ({dout0, valid0, pe0, fe0, ovr0, busy0} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_dut0 got %b want 0", {dout0, valid0, pe0, fe0, ovr0, busy0});
        end
        rx1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        q1.push_back(mk(8'h5A, 1'b0, 1'b0));
        send_frame(1, 8'h5A, 1'b1, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dout1 !== 8'h5A || q1.size() != 0) begin
            errors++;
            $display("FAIL midreset_next got d=%h pending=%0d want 5a 0", dout1, q1.size());
        end
    endtask

    initial begin : g_main
        fork
            monitor0();
            monitor1();
        join_none
        test_reset();
        test_8n1();
        test_back_to_back();
        test_parity();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
